// File: rtl/sp_ram_stream_rd_pkg.sv
// ----------------------------------------------------------------------------
// sp_ram_stream_rd_pkg
// Shared types and constants for the single-port RAM stream reader.
//   state_t        : control FSM states (IDLE / READ / DRAIN)
//   FIFO_DEPTH     : number of output buffer entries
//   FIFO_CNT_W     : width of the buffer occupancy counter
//   entry_width()  : bit width of one buffer entry {last, data} for a data width
// ----------------------------------------------------------------------------
package sp_ram_stream_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // A buffer entry is packed as {last, data[w-1:0]}; the last flag is the MSB.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/sp_ram_stream_rd_fifo2.sv
// ----------------------------------------------------------------------------
// sp_ram_stream_rd_fifo2
// Small shift-style output buffer holding {last, data} entries. Slot 0 is
// the head and is a register, so the head outputs come straight from flops.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_flush            discard all entries (same priority as reset)
//   i_push             write i_push_data/i_push_last (ignored if no room)
//   i_pop              remove the head entry (ignored when empty)
//   o_full, o_empty    occupancy flags
//   o_head_data/last   registered head entry
// ----------------------------------------------------------------------------
module sp_ram_stream_rd_fifo2
  import sp_ram_stream_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_push_last,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_head_last
);

  typedef logic [entry_width(WIDTH)-1:0] entry_t;

  entry_t                r_slot [FIFO_DEPTH];
  logic [FIFO_CNT_W-1:0] r_count;
  logic [FIFO_CNT_W-1:0] w_count_next;
  logic [FIFO_CNT_W-1:0] w_wr_pos;
  logic                  w_pop;
  logic                  w_push;
  entry_t                w_new_entry;

  assign w_pop       = i_pop && (r_count != '0);
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign w_push      = i_push && ((r_count < FIFO_CNT_W'(FIFO_DEPTH)) || w_pop);
  assign w_new_entry = {i_push_last, i_push_data};
  // Slot the new entry lands in, after any pop shift has been applied.
  assign w_wr_pos    = r_count - FIFO_CNT_W'(w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + FIFO_CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - FIFO_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      entry_t w_slot_next;

      always_comb begin
        w_slot_next = r_slot[gi];
        if (w_push && (w_wr_pos == FIFO_CNT_W'(gi))) begin
          w_slot_next = w_new_entry;
        end else if (w_pop) begin
          if (gi + 1 < FIFO_DEPTH) begin
            w_slot_next = r_slot[(gi + 1) % FIFO_DEPTH];
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
          r_slot[gi] <= '0;
        end else begin
          r_slot[gi] <= w_slot_next;
        end
      end
    end
  endgenerate

  assign o_full      = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_data = r_slot[0][WIDTH-1:0];
  assign o_head_last = r_slot[0][WIDTH];

endmodule

// File: rtl/sp_ram_stream_rd.sv
// ----------------------------------------------------------------------------
// sp_ram_stream_rd
// Read-side initiator for a single-port RAM with a combinational read port.
// Takes {address, length} commands on a valid/ready handshake, walks the RAM
// address bus (wrapping at DEPTH-1), and streams the words out with a LAST
// marker through a 2-entry registered buffer. One word per cycle when the
// sink is always ready. Never drives RAM write enables.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   CMD_VALID/READY/ADDR/LEN     command handshake
//   MEM_ADDR, MEM_Q              RAM address out, combinational read data in
//   M_VALID/READY/DATA/LAST      output stream
//   BUSY                         command in progress
//   DONE                         one-cycle completion pulse
//   ABORT, ABORTED               only when SP_RAM_STREAM_RD_ABORT_EN is defined:
//                                ABORT cancels an active command; ABORTED
//                                qualifies DONE for a cancelled command.
// ----------------------------------------------------------------------------
module sp_ram_stream_rd
  import sp_ram_stream_rd_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]  CMD_LEN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [WIDTH-1:0]      MEM_Q,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [WIDTH-1:0]      M_DATA,
  output logic                  M_LAST,
  output logic                  BUSY,
  output logic                  DONE
`ifdef SP_RAM_STREAM_RD_ABORT_EN
  ,
  input  logic                  ABORT,
  output logic                  ABORTED
`endif
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [LEN_WIDTH-1:0]  w_rem_next;
  logic                  r_done;
  logic                  w_done_next;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_flush;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
`ifdef SP_RAM_STREAM_RD_ABORT_EN
  logic                  r_aborted;
  logic                  w_aborted_next;
`endif

  assign CMD_READY = (r_state == ST_IDLE) && !RST;
  assign w_accept  = CMD_VALID && CMD_READY;
  assign w_pop     = M_VALID && M_READY;

  // Non-power-of-two depths wrap explicitly rather than by overflow.
  assign w_addr_inc = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_rem_next   = r_rem;
    w_done_next  = 1'b0;
    w_issue      = 1'b0;
    w_flush      = 1'b0;
`ifdef SP_RAM_STREAM_RD_ABORT_EN
    w_aborted_next = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_addr_next = CMD_ADDR;
          w_rem_next  = CMD_LEN;
          if (CMD_LEN == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        // Issue whenever the buffer will have room at the clock edge,
        // including the full-with-pop case so the stream never bubbles.
        if (!w_fifo_full || w_pop) begin
          w_issue     = 1'b1;
          w_addr_next = w_addr_inc;
          w_rem_next  = r_rem - LEN_WIDTH'(1);
          if (r_rem == LEN_WIDTH'(1)) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_pop && M_LAST) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
`ifdef SP_RAM_STREAM_RD_ABORT_EN
    if (ABORT && (r_state != ST_IDLE)) begin
      w_state_next   = ST_IDLE;
      w_addr_next    = r_addr;
      w_rem_next     = r_rem;
      w_issue        = 1'b0;
      w_flush        = 1'b1;
      w_done_next    = 1'b1;
      w_aborted_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_rem   <= w_rem_next;
      r_done  <= w_done_next;
    end
  end

`ifdef SP_RAM_STREAM_RD_ABORT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_aborted_next;
    end
  end
  assign ABORTED = r_aborted;
`endif

  sp_ram_stream_rd_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_flush     (w_flush),
    .i_push      (w_issue),
    .i_push_data (MEM_Q),
    .i_push_last (r_rem == LEN_WIDTH'(1)),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head_data (M_DATA),
    .o_head_last (M_LAST)
  );

  assign MEM_ADDR = r_addr;
  assign M_VALID  = !w_fifo_empty;
  assign BUSY     = (r_state != ST_IDLE);
  assign DONE     = r_done;

endmodule

// File: tb/tb_sp_ram_stream_rd.sv
// ----------------------------------------------------------------------------
// tb_sp_ram_stream_rd
// Directed commands against a RAM model preloaded with mem[i] = i + 0x10.
// Each accepted command pushes its expected {last, data} words into a
// scoreboard queue; an independent monitor pops and compares on every
// stream handshake and also watches DONE timing, CMD_READY/BUSY agreement
// and stream stability under backpressure.
// ----------------------------------------------------------------------------
module tb_sp_ram_stream_rd;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LW    = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [AW-1:0]    CMD_ADDR = '0;
  logic [LW-1:0]    CMD_LEN = '0;
  logic [AW-1:0]    MEM_ADDR;
  logic [WIDTH-1:0] MEM_Q;
  logic             M_VALID;
  logic             M_READY = 1'b0;
  logic [WIDTH-1:0] M_DATA;
  logic             M_LAST;
  logic             BUSY;
  logic             DONE;
`ifdef SP_RAM_STREAM_RD_ABORT_EN
  logic             ABORT = 1'b0;
  logic             ABORTED;
`endif

  always #5 CLK = ~CLK;

  logic [WIDTH-1:0] mem [DEPTH];
  assign MEM_Q = mem[MEM_ADDR];

  sp_ram_stream_rd #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_LEN   (CMD_LEN),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_Q     (MEM_Q),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .M_DATA    (M_DATA),
    .M_LAST    (M_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE)
`ifdef SP_RAM_STREAM_RD_ABORT_EN
    ,
    .ABORT     (ABORT),
    .ABORTED   (ABORTED)
`endif
  );

  logic [WIDTH:0] sb_q [$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             p_last_pop = 1'b0;
  logic             p_len0     = 1'b0;
  logic             p_abort    = 1'b0;
  logic             p_rst      = 1'b0;
  logic             p_stall    = 1'b0;
  logic [WIDTH-1:0] p_data     = '0;
  logic             p_last     = 1'b0;
  logic [WIDTH:0]   exp_e;
  logic             exp_done;

  always @(negedge CLK) begin
    if (mon_en) begin
      exp_done = (p_last_pop || p_len0 || p_abort) && !p_rst;
      chk("done_timing", DONE, exp_done);
`ifdef SP_RAM_STREAM_RD_ABORT_EN
      if (DONE) chk("aborted_flag", ABORTED, p_abort);
`endif
      chk("cmd_ready_vs_busy", CMD_READY, !BUSY && !RST);
      if (p_stall && !p_rst && !p_abort) begin
        chk("stall_valid", M_VALID, 1'b1);
        chk("stall_data", M_DATA, p_data);
        chk("stall_last", M_LAST, p_last);
      end
      if (M_VALID && M_READY && !RST) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", 1'b1, 1'b0);
        end else begin
          exp_e = sb_q.pop_front();
          $display("pop data=0x%02h last=%0d exp_data=0x%02h exp_last=%0d",
                   M_DATA, M_LAST, exp_e[WIDTH-1:0], exp_e[WIDTH]);
          chk("stream_data", M_DATA, exp_e[WIDTH-1:0]);
          chk("stream_last", M_LAST, exp_e[WIDTH]);
        end
      end
      p_last_pop = M_VALID && M_READY && M_LAST && !RST;
      p_len0     = CMD_VALID && CMD_READY && (CMD_LEN == '0);
`ifdef SP_RAM_STREAM_RD_ABORT_EN
      p_abort    = ABORT && BUSY && !RST;
`else
      p_abort    = 1'b0;
`endif
      p_rst      = RST;
      p_stall    = M_VALID && !M_READY && !RST;
      p_data     = M_DATA;
      p_last     = M_LAST;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_cmd(input int addr, input int len);
    bit ok;
    ok = 1'b0;
    CMD_ADDR  = AW'(addr);
    CMD_LEN   = LW'(len);
    CMD_VALID = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cmd_accept_timeout", 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    $display("cmd addr=%0d len=%0d accepted", addr, len);
    for (int i = 0; i < len; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'(((addr + i) % DEPTH) + 16);
      sb_q.push_back({(i == len - 1), d});
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (sb_q.size() == 0 && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp_a [4];
    bit ok;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 16);

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cmd_ready", CMD_READY, 1'b0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_m_valid", M_VALID, 1'b0);
    chk("rst_m_data", M_DATA, 0);
    chk("rst_m_last", M_LAST, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    chk("idle_cmd_ready", CMD_READY, 1'b1);
    @(posedge CLK);
    #1;

    // Test 1: addr 2, len 4, always ready; first word two cycles after accept.
    M_READY = 1'b1;
    send_cmd(2, 4);
    @(negedge CLK);
    chk("t1_valid_n1", M_VALID, 1'b0);
    chk("t1_busy", BUSY, 1'b1);
    @(negedge CLK);
    chk("t1_valid_n2", M_VALID, 1'b1);
    chk("t1_first_data", M_DATA, 8'h12);
    wait_idle();

    // Test 2: wrap from 7 back to 0.
    exp_a = '{6, 7, 0, 1};
    send_cmd(6, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t2_mem_addr", MEM_ADDR, exp_a[i]);
    end
    wait_idle();

    // Test 3: zero length -> DONE next cycle, no data, BUSY stays low.
    send_cmd(2, 0);
    @(negedge CLK);
    chk("t3_done", DONE, 1'b1);
    chk("t3_busy", BUSY, 1'b0);
    chk("t3_valid", M_VALID, 1'b0);
    @(negedge CLK);
    chk("t3_valid_after", M_VALID, 1'b0);
    @(posedge CLK);
    #1;

    // Test 4: full-depth read with random backpressure.
    send_cmd(0, 8);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK);
      #1;
      M_READY = 1'($urandom_range(0, 1));
      if (sb_q.size() == 0 && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("t4_timeout", 1'b0, 1'b1);
    M_READY = 1'b1;
    wait_idle();

    // Test 5: reset after the second word of a len-8 command.
    send_cmd(0, 8);
    repeat (3) @(posedge CLK);
    #1;
    RST     = 1'b1;
    M_READY = 1'b0;
    sb_q.delete();
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    M_READY = 1'b1;
    @(negedge CLK);
    chk("t5_valid_after_rst", M_VALID, 1'b0);
    chk("t5_done_after_rst", DONE, 1'b0);
    chk("t5_busy_after_rst", BUSY, 1'b0);
    @(posedge CLK);
    #1;
    send_cmd(3, 1);
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_single_data", M_DATA, 8'h13);
    chk("t5_single_last", M_LAST, 1'b1);
    wait_idle();

`ifdef SP_RAM_STREAM_RD_ABORT_EN
    // Test 6: abort after three words, then a normal command.
    send_cmd(0, 8);
    repeat (4) @(posedge CLK);
    #1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    sb_q.delete();
    @(negedge CLK);
    chk("t6_valid_dropped", M_VALID, 1'b0);
    chk("t6_done", DONE, 1'b1);
    chk("t6_aborted", ABORTED, 1'b1);
    chk("t6_busy", BUSY, 1'b0);
    @(posedge CLK);
    #1;
    send_cmd(5, 2);
    wait_idle();
`endif

    chk("final_queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
